// File: rtl/gate_sweep_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | gate_sweep_pkg                                                        |
// | Shared types and golden truth table for the gate-unit sweep sequencer |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int GATE_W  = 7;
    localparam int NUM_VEC = 4;

    // Expected {OR, AND, NOR, NAND, XOR, XNOR, NOT x} for {x,y} = 00, 01, 10, 11
    localparam logic [GATE_W-1:0] GOLDEN [NUM_VEC] = '{7'h1B, 7'h4D, 7'h4C, 7'h62};

endpackage
`default_nettype wire

// File: rtl/gate_sweep_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | gate_sweep_ctrl_if                                                    |
// | Control/status and gate-unit signals of the sweep sequencer           |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface gate_sweep_ctrl_if;
    import gate_sweep_pkg::*;

    logic                        start;
    logic [GATE_W-1:0]           gates;
    logic                        x;
    logic                        y;
    logic                        busy;
    logic                        done;
    logic                        pass;
    logic [NUM_VEC-1:0]          fail_mask;
    logic [GATE_W*NUM_VEC-1:0]   result;

    modport master (
        output start, gates,
        input  x, y, busy, done, pass, fail_mask, result
    );

    modport slave (
        input  start, gates,
        output x, y, busy, done, pass, fail_mask, result
    );

endinterface
`default_nettype wire

// File: rtl/sweep_dwell_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sweep_dwell_timer                                                     |
// | Loadable down-counter timing the per-vector dwell, with zero flag     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sweep_dwell_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic load,
    input  wire logic dec,
    output logic      zero
);

    localparam int                c_cnt_w  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(HOLD_CYCLES - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_reload;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | gate_sweep_ctrl                                                       |
// | Drives x/y through 00..11, captures gate outputs, compares to golden  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    gate_sweep_ctrl_if.slave bus
);

    state_t                      r_state;
    logic [1:0]                  r_vec;
    logic                        r_settle;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_pass;
    logic [NUM_VEC-1:0]          r_fail_mask;
    logic [GATE_W*NUM_VEC-1:0]   r_result;

    logic                        w_zero;
    logic                        w_load;
    logic                        w_dec;
    logic                        w_capture;
    logic [NUM_VEC-1:0]          w_mask_next;

    // The first vector gets one settle cycle before the dwell count starts,
    // so every capture lands at 1 + (i+1)*HOLD_CYCLES edges after acceptance.
    assign w_capture = (r_state == DRIVE) && !r_settle && w_zero;
    assign w_load    = ((r_state == IDLE) && bus.start) || (w_capture && (r_vec != 2'b11));
    assign w_dec     = (r_state == DRIVE) && !r_settle && !w_zero;

    sweep_dwell_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .dec  (w_dec),
        .zero (w_zero)
    );

    always_comb begin
        w_mask_next        = r_fail_mask;
        w_mask_next[r_vec] = (bus.gates != GOLDEN[r_vec]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_vec       <= 2'b00;
            r_settle    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= '0;
            r_result    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state     <= DRIVE;
                        r_vec       <= 2'b00;
                        r_settle    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_fail_mask <= '0;
                        r_result    <= '0;
                    end
                end
                DRIVE: begin
                    if (r_settle) begin
                        r_settle <= 1'b0;
                    end else if (w_zero) begin
                        r_result[GATE_W*int'(r_vec) +: GATE_W] <= bus.gates;
                        r_fail_mask <= w_mask_next;
                        if (r_vec == 2'b11) begin
                            r_state <= DONE;
                            r_vec   <= 2'b00;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_mask_next == '0);
                        end else begin
                            r_vec <= r_vec + 2'b01;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x         = r_vec[1];
    assign bus.y         = r_vec[0];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.fail_mask = r_fail_mask;
    assign bus.result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_gate_sweep_ctrl                                                    |
// | Two instances (H=4, H=1) against a sweep-level reference model        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_gate_sweep_ctrl;
    import gate_sweep_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [6:0] and_m;
    logic [6:0] xor_m;

    gate_sweep_ctrl_if bus4 ();
    gate_sweep_ctrl_if bus1 ();

    gate_sweep_ctrl #(.HOLD_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    gate_sweep_ctrl #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    localparam logic [6:0] GOLD_LIT [4] = '{7'h1B, 7'h4D, 7'h4C, 7'h62};

    // Behavioural gate unit, optionally corrupted by and_m / xor_m
    function automatic logic [6:0] unit(logic a, logic b);
        return {a | b, a & b, ~(a | b), ~(a & b), a ^ b, ~(a ^ b), ~a};
    endfunction

    assign bus4.start = start;
    assign bus1.start = start;
    assign bus4.gates = (unit(bus4.x, bus4.y) & and_m) ^ xor_m;
    assign bus1.gates = (unit(bus1.x, bus1.y) & and_m) ^ xor_m;

    typedef struct {
        bit          active;
        int          k;
        logic [27:0] result;
        logic [3:0]  mask;
        bit          pass;
    } model_t;

    model_t m4;
    model_t m1;
    int errors = 0;
    int checks = 0;

    // k counts edges since acceptance; captures at k = 1+(i+1)h, done at k = 4h+1
    function automatic model_t step(model_t m, int h);
        model_t n;
        int i;
        logic [6:0] g;
        n = m;
        if (rst) begin
            n.active = 0; n.k = 0; n.result = '0; n.mask = '0; n.pass = 0;
        end else if (!m.active) begin
            if (start) begin
                n.active = 1; n.k = 0; n.result = '0; n.mask = '0; n.pass = 0;
            end
        end else begin
            n.k = m.k + 1;
            if (n.k > h && n.k <= 4*h + 1 && ((n.k - 1) % h) == 0) begin
                i = (n.k - 1) / h - 1;
                g = (unit(i[1], i[0]) & and_m) ^ xor_m;
                n.result[7*i +: 7] = g;
                n.mask[i] = (g != GOLD_LIT[i]);
            end
            if (n.k == 4*h + 1) n.pass = (n.mask == 4'b0000);
            if (n.k == 4*h + 2) n.active = 0;
        end
        return n;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(string tag, model_t m, int h, logic x, logic y, logic busy,
                           logic done, logic pass, logic [3:0] fm, logic [27:0] res);
        int v;
        v = (m.active && m.k >= 1 && m.k <= 4*h) ? (m.k - 1) / h : 0;
        chk({tag, "_busy"}, 32'(busy), 32'(m.active && m.k <= 4*h));
        chk({tag, "_done"}, 32'(done), 32'(m.active && m.k == 4*h + 1));
        chk({tag, "_xy"},   32'({x, y}), 32'(v[1:0]));
        chk({tag, "_pass"}, 32'(pass), 32'(m.pass));
        chk({tag, "_mask"}, 32'(fm),   32'(m.mask));
        chk({tag, "_res"},  32'(res),  32'(m.result));
    endtask

    task automatic cycle();
        @(posedge clk);
        m4 = step(m4, 4);
        m1 = step(m1, 1);
        @(negedge clk);
        compare("h4", m4, 4, bus4.x, bus4.y, bus4.busy, bus4.done, bus4.pass, bus4.fail_mask, bus4.result);
        compare("h1", m1, 1, bus1.x, bus1.y, bus1.busy, bus1.done, bus1.pass, bus1.fail_mask, bus1.result);
    endtask

    // Pulse start, then run until the H=4 instance signals done (bounded)
    task automatic sweep(output int n4, output int n1);
        start = 1'b1;
        cycle();
        start = 1'b0;
        n4 = 0;
        n1 = -1;
        while (!bus4.done && n4 < 40) begin
            cycle();
            n4++;
            if (bus1.done && n1 < 0) n1 = n4;
        end
    endtask

    initial begin
        int n4, n1, ndone, dedge;
        m4 = '{default: 0};
        m1 = '{default: 0};
        rst = 1'b1; start = 1'b0; and_m = 7'h7F; xor_m = 7'h00;
        cycle();
        cycle();
        chk("reset_busy", 32'(bus4.busy), 32'd0);
        chk("reset_result", 32'(bus4.result), 32'd0);
        rst = 1'b0;
        cycle();

        // Clean sweep
        sweep(n4, n1);
        chk("done_edge_h4", 32'(n4), 32'd17);
        chk("done_edge_h1", 32'(n1), 32'd5);
        chk("clean_pass", 32'(bus4.pass), 32'd1);
        chk("clean_mask", 32'(bus4.fail_mask), 32'd0);
        chk("clean_result_h4", 32'(bus4.result), 32'hC53269B);
        chk("clean_result_h1", 32'(bus1.result), 32'hC53269B);
        cycle();
        cycle();

        // G output stuck at 0
        and_m = 7'h7E;
        sweep(n4, n1);
        chk("g0_mask", 32'(bus4.fail_mask), 32'b0011);
        chk("g0_pass", 32'(bus4.pass), 32'd0);
        chk("g0_v0", 32'(bus4.result[6:0]), 32'h1A);
        chk("g0_v1", 32'(bus4.result[13:7]), 32'h4C);
        and_m = 7'h7F;
        cycle();
        cycle();

        // start held high: one done at edge 17, re-accept once back in IDLE
        start = 1'b1;
        cycle();
        ndone = 0;
        dedge = -1;
        for (int j = 1; j <= 18; j++) begin
            cycle();
            if (bus4.done) begin
                ndone++;
                dedge = j;
            end
        end
        chk("held_done_count", 32'(ndone), 32'd1);
        chk("held_done_edge", 32'(dedge), 32'd17);
        chk("held_idle_pass", 32'(bus4.pass), 32'd1);
        cycle();
        chk("held_restart_busy", 32'(bus4.busy), 32'd1);
        chk("held_restart_pass", 32'(bus4.pass), 32'd0);
        start = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();

        // Reset at edge 7 mid-sweep
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int j = 1; j <= 6; j++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_outputs", 32'({bus4.x, bus4.y, bus4.busy, bus4.done, bus4.pass, bus4.fail_mask}), 32'd0);
        chk("midrst_result", 32'(bus4.result), 32'd0);
        ndone = 0;
        for (int j = 0; j < 20; j++) begin
            cycle();
            if (bus4.done) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        sweep(n4, n1);
        chk("after_rst_edge", 32'(n4), 32'd17);
        chk("after_rst_pass", 32'(bus4.pass), 32'd1);
        cycle();

        // rst and start together
        rst = 1'b1;
        start = 1'b1;
        cycle();
        rst = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 32'(bus4.busy), 32'd0);
        cycle();
        chk("rst_start_busy2", 32'(bus4.busy), 32'd0);

        // Randomized traffic, checked every cycle against the model
        for (int j = 0; j < 3000; j++) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) begin
                and_m = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h7F;
                xor_m = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
